// File: rtl/ps2_host_tx.sv
// Purpose: PS/2 host-to-device transmitter. It sends one command byte per request over open-drain clk/dat enables.
// Latency: INHIBIT_CYCLES of clock inhibit, then 11 device clocks. A done or error pulse ends the transfer.
// Backpressure: cmd_ready is high only in IDLE. A request that arrives while busy is dropped, never queued.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int PACKET_TIMEOUT = 100000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // One counter serves the inhibit, start-timeout and packet-timeout phases.
  localparam int MAX_AB = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_ALL = (MAX_AB > PACKET_TIMEOUT) ? MAX_AB : PACKET_TIMEOUT;
  localparam int CW_RAW = $clog2(MAX_ALL);
  localparam int CW = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] STA_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] PKT_LAST = CW'(PACKET_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, DONE, ERR
  } state_t;

  state_t state, state_n;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          clk_s, dat_s, fe;
  logic [9:0]    shift, shift_n;     // {stop, parity, d7..d0}; bit 0 is the next bit to drive
  logic [3:0]    bit_cnt, bit_cnt_n; // falling edges seen so far in the frame
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          clk_oe_q, clk_oe_n;
  logic          dat_oe_q, dat_oe_n;
  logic          pkt_expired;

  // Two-flop synchronizers on the raw pins, plus the previous synced clock for edge detection.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s       = clk_sync[1];
  assign dat_s       = dat_sync[1];
  assign fe          = clk_prev & ~clk_s;
  assign cnt_inc     = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
  assign pkt_expired = (cnt == PKT_LAST);

  // State, frame shifter, counters and the registered line enables.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      cnt      <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      cnt      <= cnt_n;
      clk_oe_q <= clk_oe_n;
      dat_oe_q <= dat_oe_n;
    end
  end

  // Next-state logic: frame sequencing, timeouts, and the enable values for the next cycle.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    cnt_n     = cnt_inc;
    clk_oe_n  = clk_oe_q;
    dat_oe_n  = dat_oe_q;
    case (state)
      IDLE: begin
        cnt_n    = '0;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (cmd_valid) begin
          shift_n   = {1'b1, ~^cmd_data, cmd_data};
          bit_cnt_n = '0;
          clk_oe_n  = 1'b1;
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        // Release the clock and drive the start bit in the same cycle.
        if (cnt == INH_LAST) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b1;
          cnt_n    = '0;
          state_n  = START;
        end
      end
      START: begin
        if (cnt == STA_LAST) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          state_n  = ERR;
        end else if (fe) begin
          dat_oe_n  = ~shift[0];
          shift_n   = shift >> 1;
          bit_cnt_n = 4'd1;
          cnt_n     = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (pkt_expired) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          state_n  = ERR;
        end else if (fe) begin
          // The tenth edge puts out the stop bit, which releases the data line.
          dat_oe_n  = ~shift[0];
          shift_n   = shift >> 1;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        if (pkt_expired) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          state_n  = ERR;
        end else if (fe) begin
          state_n = dat_s ? ERR : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (pkt_expired) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          state_n  = ERR;
        end else if (clk_s && dat_s) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      ERR: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        state_n  = IDLE;
      end
      default: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        state_n  = IDLE;
      end
    endcase
  end

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign error      = (state == ERR);
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Purpose: testbench for ps2_host_tx. It uses a PS/2 device model, a scoreboard queue and a decoupled monitor.
// Latency: each transfer is checked when its done or error pulse appears.
// Backpressure: a request is issued only when cmd_ready is high and the device model is idle.
module tb_ps2_host_tx;
  localparam int INH  = 8;
  localparam int STO  = 200;
  localparam int PTO  = 2000;
  localparam int HALF = 10;
  localparam int M_OK = 0, M_NOCLK = 1, M_NACK = 2, M_STALL = 3;

  logic       clk = 1'b0;
  logic       Resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  logic       line_clk, line_dat;

  assign line_clk = ~(ps2_clk_oe | dev_clk_low);
  assign line_dat = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .PACKET_TIMEOUT(PTO)) dut (
    .Clock(clk), .Resetn(Resetn), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .busy(busy), .done(done), .error(error),
    .ps2_clk_in(line_clk), .ps2_dat_in(line_dat),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int mode; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0, n_sent = 0;
  int dev_mode = 0, dev_starts = 0, dev_pulses = 0, dev_inh = 0, rel_cyc = 0, fe1_cyc = 0;
  bit dev_active = 1'b0, start_ok = 1'b0;
  logic [10:0] cap = '1;

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (bit k is the k-th bit on the wire).
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: on every done/error pulse, pop the expected transfer and compare.
  initial begin : monitor
    exp_t e;
    int pc, d;
    forever begin
      @(negedge clk);
      if (Resetn && (done || error)) begin
        pc = cyc;
        check("done_error_exclusive", int'(done && error), 0);
        check("oe_released_at_pulse", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("outcome_done", int'(done), int'(e.mode == M_OK));
          check("inhibit_len", dev_inh, INH);
          check("start_bit_driven", int'(start_ok), 1);
          if (e.mode == M_OK || e.mode == M_NACK) begin
            check("frame_bits", int'(cap), int'(ref_frame(e.data)));
          end else if (e.mode == M_NOCLK) begin
            check("start_timeout_delay", pc - rel_cyc, STO);
          end else begin
            d = pc - fe1_cyc;
            checks++;
            if (d < PTO || d > PTO + 6) begin
              errors++;
              $display("FAIL pkt_timeout_delay: got %0d expected %0d..%0d", d, PTO, PTO + 6);
            end
          end
        end
        @(negedge clk);
        check("ready_after_pulse", int'(cmd_ready), 1);
        check("busy_after_pulse", int'(busy), 0);
      end
    end
  end

  // Device model: it measures the inhibit, generates a 20-cycle clock and samples each bit before the rising edge.
  initial begin : device
    int inh, t;
    forever begin
      @(negedge clk);
      if (Resetn && ps2_clk_oe) begin
        dev_active = 1'b1;
        dev_starts++;
        inh = 0;
        cap = '1;
        dev_pulses = 0;
        while (ps2_clk_oe && inh < 1000) begin
          inh++;
          @(negedge clk);
        end
        dev_inh  = inh;
        start_ok = ps2_dat_oe;
        rel_cyc  = cyc;
        if (dev_mode != M_NOCLK) begin
          repeat ($urandom_range(2, 20)) @(negedge clk);
          cap[0] = line_dat;
          for (int k = 1; k <= 11; k++) begin
            if (k == 11 && dev_mode != M_NACK) dev_dat_low = 1'b1;
            dev_clk_low = 1'b1;
            dev_pulses  = k;
            if (k == 1) fe1_cyc = cyc;
            repeat (HALF - 1) @(negedge clk);
            if (k <= 10) cap[k] = line_dat;
            @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clk);
            dev_dat_low = 1'b0;
            repeat (HALF - 2) @(negedge clk);
            if (dev_mode == M_STALL && k == 5) break;
          end
        end
        t = 0;
        while (busy && t < 3000) begin
          t++;
          @(negedge clk);
        end
        dev_active = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] d, input int m);
    int t;
    t = 0;
    while ((!cmd_ready || dev_active) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: not ready after %0d cycles", t);
    end
    dev_mode = m;
    exp_q.push_back('{data: d, mode: m});
    n_sent++;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || dev_active) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 6000) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: still busy after %0d cycles", t);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    int t;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_dat_oe", int'(ps2_dat_oe), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    Resetn = 1'b1;
    repeat (5) @(negedge clk);

    send(8'hED, M_OK); wait_idle();
    send(8'h01, M_OK); wait_idle();
    send(8'hFF, M_OK); wait_idle();
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom_range(0, 255)), M_OK);
      wait_idle();
    end
    send(8'($urandom_range(0, 255)), M_NOCLK); wait_idle();
    send(8'($urandom_range(0, 255)), M_NACK);  wait_idle();
    send(8'($urandom_range(0, 255)), M_STALL); wait_idle();

    // A request held while busy must be dropped.
    send(8'h3C, M_OK);
    repeat (20) @(negedge clk);
    cmd_data  = 8'h55;
    cmd_valid = 1'b1;
    repeat (30) @(negedge clk);
    check("busy_during_ignored_req", int'(busy), 1);
    cmd_valid = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check("no_queued_send", int'(busy), 0);

    // Asynchronous reset while d3 of 0xA5 (a 0 bit) is on the line.
    send(8'hA5, M_OK);
    t = 0;
    while (dev_pulses < 4 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    check("d3_driven_low", int'(ps2_dat_oe), 1);
    #2 Resetn = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_clk_oe", int'(ps2_clk_oe), 0);
    check("midreset_dat_oe", int'(ps2_dat_oe), 0);
    check("midreset_cmd_ready", int'(cmd_ready), 1);
    check("midreset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    Resetn = 1'b1;
    wait_idle();
    repeat (20) @(negedge clk);
    check("no_resume_busy", int'(busy), 0);
    check("no_resume_clk_oe", int'(ps2_clk_oe), 0);

    send(8'($urandom_range(0, 255)), M_OK); wait_idle();

    check("inhibit_starts", dev_starts, n_sent);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
